// File: rtl/ahb_rr_arbiter.sv
// ============================================================================
// Module      : ahb_rr_arbiter
// Description : Round-robin AHB bus arbiter. Produces a one-hot grant plus
//               registered HMASTER/HMASTLOCK, holding ownership across
//               fixed-length bursts and locked sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ahb_rr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int NUM_MASTER_BITS = 2,
    parameter int DEFAULT_MASTER  = 0
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_MASTERS-1:0]     HBUSREQ,
    input  logic [NUM_MASTERS-1:0]     HLOCK,
    input  logic [1:0]                 HTRANS,
    input  logic [2:0]                 HBURST,
    input  logic                       HREADY,
    output logic [NUM_MASTERS-1:0]     HGRANT,
    output logic [NUM_MASTER_BITS-1:0] HMASTER,
    output logic                       HMASTLOCK
);

    localparam logic [NUM_MASTER_BITS-1:0] c_default = NUM_MASTER_BITS'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0]     c_one     = NUM_MASTERS'(1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_busy   = 2'd1;
    localparam logic [1:0] c_nonseq = 2'd2;
    localparam logic [1:0] c_seq    = 2'd3;

    localparam logic [1:0] S_ARB   = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    logic [1:0]                 r_state;
    logic [3:0]                 r_count;
    logic [NUM_MASTERS-1:0]     r_grant;
    logic [NUM_MASTER_BITS-1:0] r_owner;
    logic [NUM_MASTER_BITS-1:0] r_last;
    logic [NUM_MASTER_BITS-1:0] r_master;
    logic                       r_mastlock;

    logic [NUM_MASTER_BITS-1:0] w_winner;
    logic                       w_found;
    logic                       w_lock_owner;
    logic                       w_burst_start;
    logic [3:0]                 w_burst_len_m1;
    logic                       w_rearb;

    // Rotating search starting just after the last master that actually won.
    always_comb begin
        w_winner = c_default;
        w_found  = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            int idx;
            idx = (int'(r_last) + i) % NUM_MASTERS;
            if (!w_found && HBUSREQ[idx]) begin
                w_winner = NUM_MASTER_BITS'(idx);
                w_found  = 1'b1;
            end
        end
    end

    assign w_lock_owner  = HLOCK[r_owner];
    assign w_burst_start = (HTRANS == c_nonseq) && (HBURST[2:1] != 2'b00);

    always_comb begin
        case (HBURST[2:1])
            2'b01:   w_burst_len_m1 = 4'd3;
            2'b10:   w_burst_len_m1 = 4'd7;
            2'b11:   w_burst_len_m1 = 4'd15;
            default: w_burst_len_m1 = 4'd0;
        endcase
    end

    always_comb begin
        case (r_state)
            S_ARB:   w_rearb = !w_burst_start && !w_lock_owner;
            S_BURST: w_rearb = (HTRANS == c_idle) || (HTRANS == c_nonseq) ||
                               ((HTRANS == c_seq) && (r_count <= 4'd1));
            S_LOCK:  w_rearb = !w_lock_owner;
            default: w_rearb = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= S_ARB;
            r_count    <= 4'd0;
            r_grant    <= c_one << c_default;
            r_owner    <= c_default;
            r_last     <= c_default;
            r_master   <= c_default;
            r_mastlock <= 1'b0;
        end else if (HREADY) begin
            // Address-phase owner trails the grant by one accepted cycle.
            r_master   <= r_owner;
            r_mastlock <= w_lock_owner;

            if (w_rearb) begin
                r_grant <= c_one << w_winner;
                r_owner <= w_winner;
                if (w_found) begin
                    r_last <= w_winner;
                end
                r_state <= S_ARB;
                r_count <= 4'd0;
            end else begin
                case (r_state)
                    S_ARB: begin
                        if (w_burst_start) begin
                            r_state <= S_BURST;
                            r_count <= w_burst_len_m1;
                        end else begin
                            r_state <= S_LOCK;
                        end
                    end
                    S_BURST: begin
                        if (HTRANS == c_seq) begin
                            r_count <= r_count - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule

`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
// ============================================================================
// Module      : tb_ahb_rr_arbiter
// Description : Self-checking bench for ahb_rr_arbiter: directed vector table
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_rr_arbiter;

    localparam int NM  = 4;
    localparam int DEF = 0;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .NUM_MASTER_BITS(2),
        .DEFAULT_MASTER (DEF)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [3:0] grant;
        logic [1:0] master;
        logic       mlock;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: who owns the grant, round-robin pointer, ownership mode.
    int m_owner, m_ptr, m_master, m_mode, m_left;
    bit m_mlock;

    function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                                input logic [1:0] trans, input logic [2:0] burst, input logic ready,
                                input logic [3:0] grant, input logic [1:0] master, input logic mlock);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
        v.ready = ready; v.grant = grant; v.master = master; v.mlock = mlock;
        vecs.push_back(v);
    endfunction

    // Requester closest after the pointer in rotation order, or -1 if none.
    function automatic int pick_winner(input logic [3:0] req);
        int best  = -1;
        int bestd = NM;
        for (int i = 0; i < NM; i++) begin
            if (req[i]) begin
                int d;
                d = (i - m_ptr - 1 + 2 * NM) % NM;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic void model_rearb();
        int w;
        w = pick_winner(HBUSREQ);
        if (w < 0) begin
            m_owner = DEF;
        end else begin
            m_owner = w;
            m_ptr   = w;
        end
        m_mode = 0;
    endfunction

    function automatic void model_step();
        int prev_owner;
        if (HRESET) begin
            m_owner = DEF; m_ptr = DEF; m_master = DEF; m_mlock = 0; m_mode = 0; m_left = 0;
            return;
        end
        if (!HREADY) return;
        prev_owner = m_owner;
        case (m_mode)
            0: begin
                if (HTRANS == 2'd2 && HBURST >= 3'd2) begin
                    m_left = (2 << (HBURST >> 1)) - 1;
                    m_mode = 1;
                end else if (HLOCK[m_owner]) begin
                    m_mode = 2;
                end else begin
                    model_rearb();
                end
            end
            1: begin
                if (HTRANS == 2'd3) begin
                    m_left--;
                    if (m_left == 0) model_rearb();
                end else if (HTRANS != 2'd1) begin
                    model_rearb();
                end
            end
            default: begin
                if (!HLOCK[m_owner]) model_rearb();
            end
        endcase
        m_master = prev_owner;
        m_mlock  = HLOCK[prev_owner];
    endfunction

    task automatic tick();
        @(posedge HCLK);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    initial begin
        HRESET = 1; HBUSREQ = 0; HLOCK = 0; HTRANS = 0; HBURST = 0; HREADY = 1;
        m_owner = DEF; m_ptr = DEF; m_master = DEF; m_mlock = 0; m_mode = 0; m_left = 0;

        //   rst req      lock     tr    bst   rdy  grant    mst  mlk
        add(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd0, 0);
        // Rotation over masters 0,1,3.
        add(0, 4'b1011, 4'b0000, 2'd2, 3'd0, 1, 4'b0010, 2'd0, 0);
        add(0, 4'b1011, 4'b0000, 2'd2, 3'd0, 1, 4'b1000, 2'd1, 0);
        add(0, 4'b1011, 4'b0000, 2'd2, 3'd0, 1, 4'b0001, 2'd3, 0);
        add(0, 4'b1011, 4'b0000, 2'd2, 3'd0, 1, 4'b0010, 2'd0, 0);
        // INCR4 by master 1 while master 2 waits.
        add(0, 4'b0110, 4'b0000, 2'd2, 3'd3, 1, 4'b0010, 2'd1, 0);
        add(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1, 4'b0010, 2'd1, 0);
        add(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1, 4'b0010, 2'd1, 0);
        add(0, 4'b0110, 4'b0000, 2'd3, 3'd3, 1, 4'b0100, 2'd1, 0);
        // Master 2 locked for three transfers, then hand-off to master 3.
        add(0, 4'b1101, 4'b0100, 2'd2, 3'd0, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b1101, 4'b0100, 2'd2, 3'd0, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b1101, 4'b0100, 2'd2, 3'd0, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b1001, 4'b0000, 2'd2, 3'd0, 1, 4'b1000, 2'd2, 0);
        // INCR8 by master 3 with a four-cycle wait state in the middle.
        add(0, 4'b0011, 4'b0000, 2'd2, 3'd5, 1, 4'b1000, 2'd3, 0);
        add(0, 4'b0011, 4'b0000, 2'd3, 3'd5, 1, 4'b1000, 2'd3, 0);
        add(0, 4'b0011, 4'b0000, 2'd3, 3'd5, 1, 4'b1000, 2'd3, 0);
        for (int i = 0; i < 4; i++)
            add(0, 4'b0011, 4'b0000, 2'd3, 3'd5, 0, 4'b1000, 2'd3, 0);
        for (int i = 0; i < 4; i++)
            add(0, 4'b0011, 4'b0000, 2'd3, 3'd5, 1, 4'b1000, 2'd3, 0);
        add(0, 4'b0011, 4'b0000, 2'd3, 3'd5, 1, 4'b0001, 2'd3, 0);
        // Reset during a locked INCR16 owned by master 2.
        add(0, 4'b0100, 4'b0100, 2'd0, 3'd0, 1, 4'b0100, 2'd0, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 3'd7, 1, 4'b0100, 2'd2, 1);
        add(0, 4'b0100, 4'b0100, 2'd3, 3'd7, 1, 4'b0100, 2'd2, 1);
        add(1, 4'b0100, 4'b0100, 2'd3, 3'd7, 0, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd0, 0);
        add(0, 4'b1010, 4'b0000, 2'd0, 3'd0, 1, 4'b0010, 2'd0, 0);

        foreach (vecs[k]) begin
            HRESET = vecs[k].rst; HBUSREQ = vecs[k].req; HLOCK = vecs[k].lock;
            HTRANS = vecs[k].trans; HBURST = vecs[k].burst; HREADY = vecs[k].ready;
            tick();
            check("vec_grant",  k, 32'(HGRANT),    32'(vecs[k].grant));
            check("vec_master", k, 32'(HMASTER),   32'(vecs[k].master));
            check("vec_mlock",  k, 32'(HMASTLOCK), 32'(vecs[k].mlock));
        end

        for (int n = 0; n < 3000; n++) begin
            int r;
            HRESET  = ($urandom_range(0, 149) == 0);
            HBUSREQ = 4'($urandom_range(0, 15));
            for (int b = 0; b < NM; b++)
                if ($urandom_range(0, 9) == 0) HLOCK[b] = ~HLOCK[b];
            r = $urandom_range(0, 9);
            HTRANS = (r < 2) ? 2'd0 : (r == 2) ? 2'd1 : (r < 5) ? 2'd2 : 2'd3;
            HBURST = 3'($urandom_range(0, 7));
            HREADY = ($urandom_range(0, 3) != 0);
            tick();
            check("rnd_grant",  n, 32'(HGRANT),    32'(4'b0001 << m_owner));
            check("rnd_master", n, 32'(HMASTER),   32'(m_master));
            check("rnd_mlock",  n, 32'(HMASTLOCK), 32'(m_mlock));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
